shift_normalizer: RTL and testbench
===================================

# shift_normalizer

Sequential normalizer for the datapath shift unit. It takes a 32-bit operand and repeatedly shifts it by at most 7 bits per cycle until the leading 1 reaches the MSB. It reports the normalized value and the total shift count, so the datapath can later undo the normalization with a shift of the same amount in the opposite direction. It sits beside the ALU/shift stage and runs under a start/done handshake.

## Interface
- N, 32, operand width
- MAX_STEP, 7, largest shift applied in one cycle
- CNT_W, 6, width of the count output; must hold N, so $clog2(N+1)
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- Start  in  1  request; sampled only in IDLE
- RN_In  in  N  operand; captured on the accepted Start edge
- Dir_Sel  in  1  only with NORM_RIGHT_EN; 1 = right (trailing zeros), 0 = left; captured with RN_In
- Shift_Out  out  N  normalized operand
- Count_Out  out  CNT_W  total bits shifted
- Zero_Out  out  1  operand was zero
- Busy  out  1  high in BUSY
- Done  out  1  one-cycle pulse when results are valid

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - Start=1 → capture RN_In into work register W, clear count C, go to BUSY.
  - Start=0 → stay in IDLE.
- BUSY, each cycle, in this order:
  - If W==0: set Zero_Out=1, C=0, go to DONE.
  - Else if the target bit is 1 (W[N-1] for left; W[0] for right): go to DONE, no shift.
  - Else: k = leading-zero count of W (trailing-zero count for right), saturated to MAX_STEP. W shifts by k, zero-fill; C = C + k.
- DONE: Done=1 for exactly one cycle, then IDLE unconditionally.
- Shift_Out, Count_Out and Zero_Out are registered. They update on the DONE-entry edge and hold until the next DONE.
- Zero_Out is cleared on every accepted Start.
- Start in BUSY or DONE is ignored; no queuing.
- C never exceeds N-1 for a nonzero operand; no wrap.
- Reset mid-operation aborts the operation: state IDLE, outputs at their reset values.

## Timing
- Reset values: Shift_Out=0, Count_Out=0, Zero_Out=0, Busy=0, Done=0, state IDLE.
- Let the accepted Start be edge 0 and S = ceil(lz/MAX_STEP), where lz is the leading-zero count (trailing-zero count for right mode).
- Busy is high after edge 0 through edge S+1.
- Done is high in the cycle after edge S+1, with results valid in that same cycle.
- Zero operand: S=0, so Done follows edge 1.
- Worst case (RN_In=1, left): S=5, Done follows edge 6.
- Back-to-back: Start in the Done cycle is ignored. The next request is accepted one cycle later, in IDLE.

## Configuration
- NORM_RIGHT_EN defined:
  - Dir_Sel port exists.
  - Right mode counts trailing zeros and shifts right until W[0]=1.
- NORM_RIGHT_EN undefined:
  - Dir_Sel port is absent.
  - Block is left-only; no right-shift logic is synthesized.

## Structure
- Package norm_pkg holds:
  - typedef norm_state_t {IDLE, BUSY, DONE}
  - localparam MAX_STEP=7
- Sub-module norm_step_cnt: combinational saturating zero count. Inputs W and direction; output k in 0..MAX_STEP, computed over the first MAX_STEP bits from the target end.

## Test plan
- Left, RN_In=32'h0000_0001 → Done after edge 6; Shift_Out=32'h8000_0000, Count_Out=31, Zero_Out=0.
- Left, RN_In=32'h8000_0000 → Done after edge 1; Shift_Out=32'h8000_0000, Count_Out=0.
- Left, RN_In=32'h00F0_0000 → steps of 7 then 1; Shift_Out=32'hF000_0000, Count_Out=8; Done after edge 3.
- RN_In=0 → Done after edge 1; Zero_Out=1, Shift_Out=0, Count_Out=0. A following nonzero Start clears Zero_Out.
- Start pulsed in BUSY and in the Done cycle → ignored; Count_Out reflects only the first operand. Assert reset_n low during BUSY → all outputs 0 immediately, IDLE on release.
- NORM_RIGHT_EN, Dir_Sel=1, RN_In=32'h0000_0100 → Shift_Out=32'h0000_0001, Count_Out=8; Done after edge 3.

Source files
------------

// File: rtl/shift_normalizer_pkg.sv
// Shared types and sizing for the shift normalizer.
// NORM_RIGHT_EN enables right (trailing-zero) mode.
package norm_pkg;

  localparam int N        = 32;
  localparam int MAX_STEP = 7;
  localparam int CNT_W    = $clog2(N + 1);
  localparam int K_W      = $clog2(MAX_STEP + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } norm_state_t;

  typedef enum logic {
    DIR_LEFT,
    DIR_RIGHT
  } norm_dir_t;

endpackage

// File: rtl/shift_normalizer_if.sv
// Start/done handshake and data bus of the normalizer.
// Dir_Sel exists only when NORM_RIGHT_EN is defined.
interface shift_normalizer_if;
  import norm_pkg::*;

  logic             Start;
  logic [N-1:0]     RN_In;
`ifdef NORM_RIGHT_EN
  logic             Dir_Sel;
`endif
  logic [N-1:0]     Shift_Out;
  logic [CNT_W-1:0] Count_Out;
  logic             Zero_Out;
  logic             Busy;
  logic             Done;

  modport master (
    output Start,
    output RN_In,
`ifdef NORM_RIGHT_EN
    output Dir_Sel,
`endif
    input  Shift_Out,
    input  Count_Out,
    input  Zero_Out,
    input  Busy,
    input  Done
  );

  modport slave (
    input  Start,
    input  RN_In,
`ifdef NORM_RIGHT_EN
    input  Dir_Sel,
`endif
    output Shift_Out,
    output Count_Out,
    output Zero_Out,
    output Busy,
    output Done
  );

endinterface

// File: rtl/shift_normalizer_step.sv
// Saturating zero count from the target end of W.
// Looks only at the first MAX_STEP bits; result 0..MAX_STEP.
module norm_step_cnt
  import norm_pkg::*;
(
  input  logic [N-1:0]   w_i,
  input  norm_dir_t      dir_i,
  output logic [K_W-1:0] k_o
);

  logic stop;

  // count zeros until the first one or the step limit
  always_comb begin
    k_o  = '0;
    stop = 1'b0;
    for (int i = 0; i < MAX_STEP; i++) begin
      if (!stop &&
          !((dir_i == DIR_RIGHT) ? w_i[i]
                                 : w_i[N-1-i]))
        k_o = k_o + 1'b1;
      else
        stop = 1'b1;
    end
  end

endmodule

// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer, at most MAX_STEP bits per cycle.
// NORM_RIGHT_EN adds right mode via Dir_Sel.
module shift_normalizer
  import norm_pkg::*;
(
  input logic               clk,
  input logic               reset_n,
  shift_normalizer_if.slave bus
);

  norm_state_t      state_q;
  logic [N-1:0]     w_q;
  logic [N-1:0]     w_d;
  logic [CNT_W-1:0] c_q;
  logic [CNT_W-1:0] c_d;
  logic [N-1:0]     shift_q;
  logic [CNT_W-1:0] count_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;
  logic [K_W-1:0]   k_w;
  logic             tgt_w;
  norm_dir_t        dir_w;

`ifdef NORM_RIGHT_EN
  norm_dir_t dir_q;

  // direction is captured together with the operand
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      dir_q <= DIR_LEFT;
    else if (state_q == IDLE && bus.Start)
      dir_q <= norm_dir_t'(bus.Dir_Sel);
  end

  assign dir_w = dir_q;
`else
  assign dir_w = DIR_LEFT;
`endif

  norm_step_cnt u_step (
    .w_i   (w_q),
    .dir_i (dir_w),
    .k_o   (k_w)
  );

  // one step toward the target end, plus count
  always_comb begin
    c_d = c_q + CNT_W'(k_w);
`ifdef NORM_RIGHT_EN
    if (dir_w == DIR_RIGHT) begin
      tgt_w = w_q[0];
      w_d   = w_q >> k_w;
    end else begin
      tgt_w = w_q[N-1];
      w_d   = w_q << k_w;
    end
`else
    tgt_w = w_q[N-1];
    w_d   = w_q << k_w;
`endif
  end

  // control FSM with registered results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      c_q     <= '0;
      shift_q <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.Start) begin
            w_q     <= bus.RN_In;
            c_q     <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (w_q == '0) begin
            zero_q  <= 1'b1;
            shift_q <= '0;
            count_q <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (tgt_w) begin
            shift_q <= w_q;
            count_q <= c_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            w_q <= w_d;
            c_q <= c_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.Shift_Out = shift_q;
  assign bus.Count_Out = count_q;
  assign bus.Zero_Out  = zero_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// Bench for shift_normalizer: directed and random ops
// against a leading/trailing-zero reference model.
module tb_shift_normalizer;
  import norm_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  int          o_lat;
  int          o_bcnt;
  logic [31:0] o_sh;
  logic [5:0]  o_cnt;
  logic        o_zr;
  logic        o_zclr;
  logic        o_done2;
  logic        o_busy2;

  typedef struct {
    logic [31:0] x;
    bit          r;
    logic [31:0] sh;
    int          cnt;
    bit          zr;
    int          lat;
  } vec_t;

  shift_normalizer_if bus ();

  shift_normalizer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic ref_norm(
    input  logic [31:0] x,
    input  bit          right,
    output logic [31:0] sh,
    output int          cnt,
    output bit          zr,
    output int          lat
  );
    int z;
    z = 0;
    if (x == 32'h0) begin
      sh = 32'h0; cnt = 0; zr = 1'b1; lat = 1;
    end else begin
      if (right) while (!x[z]) z++;
      else       while (!x[31-z]) z++;
      sh  = right ? (x >> z) : (x << z);
      cnt = z;
      zr  = 1'b0;
      lat = (z + MAX_STEP - 1) / MAX_STEP + 1;
    end
  endtask

  // called at a negedge; returns at the negedge
  // of the IDLE cycle following the Done cycle
  task automatic run_op(
    input logic [31:0] x,
    input bit          right,
    input bit          extra
  );
    bus.Start = 1'b1;
    bus.RN_In = x;
`ifdef NORM_RIGHT_EN
    bus.Dir_Sel = right;
`endif
    @(posedge clk);
    @(negedge clk);
    o_zclr    = bus.Zero_Out;
    bus.Start = extra;
    if (extra) bus.RN_In = ~x;
    o_lat  = -1;
    o_bcnt = 0;
    for (int e = 0; e < 20; e++) begin
      if (bus.Done) begin
        o_lat = e;
        break;
      end
      if (bus.Busy) o_bcnt++;
      @(posedge clk);
      @(negedge clk);
    end
    o_sh  = bus.Shift_Out;
    o_cnt = bus.Count_Out;
    o_zr  = bus.Zero_Out;
    @(posedge clk);
    @(negedge clk);
    o_done2   = bus.Done;
    o_busy2   = bus.Busy;
    bus.Start = 1'b0;
  endtask

  task automatic test_reset();
    bus.Start = 1'b0;
    bus.RN_In = 32'h0;
`ifdef NORM_RIGHT_EN
    bus.Dir_Sel = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.Shift_Out !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_shift: got %h want 0",
               bus.Shift_Out);
    end
    n_tests++;
    if (bus.Count_Out !== 6'd0) begin
      n_fail++;
      $display("FAIL rst_count: got %0d want 0",
               bus.Count_Out);
    end
    n_tests++;
    if (bus.Zero_Out !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_zero: got %b want 0",
               bus.Zero_Out);
    end
    n_tests++;
    if (bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy: got %b want 0",
               bus.Busy);
    end
    n_tests++;
    if (bus.Done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_done: got %b want 0",
               bus.Done);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: got busy=%b done=%b want 0 0",
               bus.Busy, bus.Done);
    end
  endtask

  task automatic test_vectors();
    vec_t v[$];
    v.push_back('{32'h0000_0001, 1'b0, 32'h8000_0000, 31, 1'b0, 6});
    v.push_back('{32'h8000_0000, 1'b0, 32'h8000_0000, 0, 1'b0, 1});
    v.push_back('{32'h00F0_0000, 1'b0, 32'hF000_0000, 8, 1'b0, 3});
    v.push_back('{32'h0000_0000, 1'b0, 32'h0000_0000, 0, 1'b1, 1});
    v.push_back('{32'h4000_0000, 1'b0, 32'h8000_0000, 1, 1'b0, 2});
`ifdef NORM_RIGHT_EN
    v.push_back('{32'h0000_0100, 1'b1, 32'h0000_0001, 8, 1'b0, 3});
    v.push_back('{32'h8000_0000, 1'b1, 32'h0000_0001, 31, 1'b0, 6});
`endif
    foreach (v[i]) begin
      run_op(v[i].x, v[i].r, 1'b0);
      n_tests++;
      if (o_lat !== v[i].lat) begin
        n_fail++;
        $display("FAIL vec_lat[%0d]: got %0d want %0d",
                 i, o_lat, v[i].lat);
      end
      n_tests++;
      if (o_bcnt !== v[i].lat) begin
        n_fail++;
        $display("FAIL vec_busy[%0d]: got %0d want %0d",
                 i, o_bcnt, v[i].lat);
      end
      n_tests++;
      if (o_sh !== v[i].sh) begin
        n_fail++;
        $display("FAIL vec_shift[%0d]: got %h want %h",
                 i, o_sh, v[i].sh);
      end
      n_tests++;
      if (o_cnt !== 6'(v[i].cnt)) begin
        n_fail++;
        $display("FAIL vec_count[%0d]: got %0d want %0d",
                 i, o_cnt, v[i].cnt);
      end
      n_tests++;
      if (o_zr !== v[i].zr) begin
        n_fail++;
        $display("FAIL vec_zero[%0d]: got %b want %b",
                 i, o_zr, v[i].zr);
      end
      n_tests++;
      if (o_zclr !== 1'b0) begin
        n_fail++;
        $display("FAIL vec_zclr[%0d]: got %b want 0",
                 i, o_zclr);
      end
      n_tests++;
      if (o_done2 !== 1'b0 || o_busy2 !== 1'b0) begin
        n_fail++;
        $display("FAIL vec_post[%0d]: got done=%b busy=%b want 0 0",
                 i, o_done2, o_busy2);
      end
    end
  endtask

  task automatic test_ignore_start();
    run_op(32'h0000_0001, 1'b0, 1'b1);
    n_tests++;
    if (o_cnt !== 6'd31 || o_sh !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL ign_result: got %h/%0d want 80000000/31",
               o_sh, o_cnt);
    end
    n_tests++;
    if (o_lat !== 6) begin
      n_fail++;
      $display("FAIL ign_lat: got %0d want 6", o_lat);
    end
    n_tests++;
    if (o_busy2 !== 1'b0 || o_done2 !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_done_start: got busy=%b done=%b want 0 0",
               o_busy2, o_done2);
    end
  endtask

  task automatic test_back_to_back();
    run_op(32'h00F0_0000, 1'b0, 1'b1);
    n_tests++;
    if (o_cnt !== 6'd8 || o_lat !== 3) begin
      n_fail++;
      $display("FAIL b2b_first: got cnt=%0d lat=%0d want 8 3",
               o_cnt, o_lat);
    end
    run_op(32'h0000_0003, 1'b0, 1'b0);
    n_tests++;
    if (o_cnt !== 6'd30 || o_sh !== 32'hC000_0000) begin
      n_fail++;
      $display("FAIL b2b_second: got %h/%0d want c0000000/30",
               o_sh, o_cnt);
    end
    n_tests++;
    if (o_lat !== 6 || o_bcnt !== 6) begin
      n_fail++;
      $display("FAIL b2b_timing: got lat=%0d busy=%0d want 6 6",
               o_lat, o_bcnt);
    end
  endtask

  task automatic test_reset_mid();
    bit act;
    bus.Start = 1'b1;
    bus.RN_In = 32'h0000_0001;
`ifdef NORM_RIGHT_EN
    bus.Dir_Sel = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: got %b want 1", bus.Busy);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus.Shift_Out !== 32'h0 || bus.Count_Out !== 6'd0 ||
        bus.Zero_Out !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_out: got %h/%0d/%b want 0/0/0",
               bus.Shift_Out, bus.Count_Out, bus.Zero_Out);
    end
    n_tests++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_ctl: got busy=%b done=%b want 0 0",
               bus.Busy, bus.Done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    act = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.Busy || bus.Done) act = 1'b1;
    end
    n_tests++;
    if (act !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_idle: got activity=%b want 0", act);
    end
    run_op(32'h00F0_0000, 1'b0, 1'b0);
    n_tests++;
    if (o_cnt !== 6'd8 || o_lat !== 3) begin
      n_fail++;
      $display("FAIL mid_recover: got cnt=%0d lat=%0d want 8 3",
               o_cnt, o_lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] x;
    logic [31:0] e_sh;
    int          e_cnt;
    bit          e_zr;
    int          e_lat;
    bit          r;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) x = 32'h0;
      else x = $urandom >> $urandom_range(0, 31);
`ifdef NORM_RIGHT_EN
      r = 1'($urandom_range(0, 1));
      if (r && x != 32'h0) x = x << $urandom_range(0, 31);
      if (x == 32'h0 && $urandom_range(0, 1) == 1)
        x = 32'h1 << $urandom_range(0, 31);
`else
      r = 1'b0;
`endif
      ref_norm(x, r, e_sh, e_cnt, e_zr, e_lat);
      run_op(x, r, 1'($urandom_range(0, 1)));
      n_tests++;
      if (o_lat !== e_lat || o_bcnt !== e_lat) begin
        n_fail++;
        $display("FAIL rnd_timing[%0d] x=%h: got lat=%0d busy=%0d want %0d",
                 i, x, o_lat, o_bcnt, e_lat);
      end
      n_tests++;
      if (o_sh !== e_sh || o_cnt !== 6'(e_cnt) ||
          o_zr !== e_zr) begin
        n_fail++;
        $display("FAIL rnd_result[%0d] x=%h: got %h/%0d/%b want %h/%0d/%b",
                 i, x, o_sh, o_cnt, o_zr, e_sh, e_cnt, e_zr);
      end
      n_tests++;
      if (o_zclr !== 1'b0 || o_done2 !== 1'b0 ||
          o_busy2 !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_hs[%0d]: got zclr=%b done2=%b busy2=%b want 0 0 0",
                 i, o_zclr, o_done2, o_busy2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
